// File: rtl/tile_renderer.sv
// tile_renderer: three-stage VGA pixel pipeline. Looks up the tile code for
// the scan position in the level tile map, overlays the Mario and Goomba
// sprites and emits a 12-bit colour three cycles after the pixel enters.
// Optional coin blink animation is enabled by defining TILE_RENDERER_BLINK_EN;
// without it frame_start is ignored and coins always render in 0xFD0.
module tile_renderer (
  input  logic                     i_vga_clock,
  input  logic                     i_reset,
  input  logic [11:0][16:0][7:0]   i_background,
  input  logic [9:0]               i_pixel_x,
  input  logic [9:0]               i_pixel_y,
  input  logic                     i_pixel_valid,
  input  logic                     i_frame_start,
  input  logic signed [31:0]       i_mario_x,
  input  logic signed [31:0]       i_mario_y,
  input  logic signed [31:0]       i_goomba_x,
  input  logic signed [31:0]       i_goomba_y,
  output logic [11:0]              o_rgb,
  output logic                     o_rgb_valid
);

  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;
  localparam logic [7:0] TKN = 8'd4;
  localparam logic [7:0] CK1 = 8'd5;
  localparam logic [7:0] CK2 = 8'd6;

  localparam int unsigned CHARACTER_WIDTH = 42;
  localparam int unsigned SCREEN_WIDTH    = 640;
  localparam int unsigned SCREEN_HEIGHT   = 480;
  localparam int unsigned BLOCK_WIDTH     = 40;
  localparam int unsigned ROWS            = 12;
  localparam int unsigned COLS            = 16;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_SKY    = 12'h6AF;
  localparam logic [11:0] RGB_BRICK  = 12'hA52;
  localparam logic [11:0] RGB_GROUND = 12'h840;
  localparam logic [11:0] RGB_COIN   = 12'hFD0;
  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] RGB_BAD    = 12'hF0F;
  localparam logic [11:0] RGB_MARIO  = 12'hF00;
  localparam logic [11:0] RGB_GOOMBA = 12'h830;

  // Pixel p lies inside the sprite span starting at s (33-bit signed difference
  // so negative and very large sprite coordinates clip without overflow).
  function automatic logic f_hit(input logic [9:0] p, input logic signed [31:0] s);
    logic signed [32:0] d;
    d = $signed({23'd0, p}) - 33'(s);
    return !d[32] && (d[31:0] < 32'(CHARACTER_WIDTH));
  endfunction

  // Tile code to colour; coins fall back to sky colour while hidden.
  function automatic logic [11:0] f_palette(input logic [7:0] code, input logic hide);
    logic [11:0] c;
    case (code)
      BDR:     c = RGB_BLACK;
      SKY:     c = RGB_SKY;
      BLK:     c = RGB_BRICK;
      GND:     c = RGB_GROUND;
      TKN:     c = hide ? RGB_SKY : RGB_COIN;
      CK1:     c = RGB_WHITE;
      CK2:     c = RGB_BLACK;
      default: c = RGB_BAD;
    endcase
    return c;
  endfunction

  logic                 w_hide;

  logic [3:0]           w_row;
  logic [3:0]           w_col;
  logic                 w_off;
  logic [15:0][7:0]     w_row_bytes;
  logic [11:0][7:0]     w_col0_unused;

  logic                 r1_valid;
  logic                 r1_off;
  logic [9:0]           r1_x;
  logic [9:0]           r1_y;
  logic [3:0]           r1_col;
  logic [15:0][7:0]     r1_row_bytes;
  logic signed [31:0]   r1_mario_x;
  logic signed [31:0]   r1_mario_y;
  logic signed [31:0]   r1_goomba_x;
  logic signed [31:0]   r1_goomba_y;

  logic                 w_mario_hit;
  logic                 w_goomba_hit;
  logic [7:0]           w_code;

  logic                 r2_valid;
  logic                 r2_off;
  logic                 r2_mario;
  logic                 r2_goomba;
  logic [7:0]           r2_code;

  logic [11:0]          w_color;

  // Row/column by constant-compare chain; each threshold passed adds one.
  always_comb begin
    w_row = '0;
    w_col = '0;
    for (int unsigned k = 1; k < ROWS; k++) begin
      if (i_pixel_y >= 10'(k * BLOCK_WIDTH)) w_row = w_row + 4'd1;
    end
    for (int unsigned k = 1; k < COLS; k++) begin
      if (i_pixel_x >= 10'(k * BLOCK_WIDTH)) w_col = w_col + 4'd1;
    end
    w_off = (i_pixel_x >= 10'(SCREEN_WIDTH)) || (i_pixel_y >= 10'(SCREEN_HEIGHT));
  end

  // Capture the addressed map row now so later map writes do not affect this pixel.
  // Element x=0 of every row is never on screen and is not captured.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      w_row_bytes[j] = i_background[4'd11 - w_row][j + 1];
    end
    for (int r = 0; r < 12; r++) begin
      w_col0_unused[r] = i_background[r][0];
    end
  end

  // Stage 1: pixel, sprite coordinates, column, map row and off-screen flag.
  always_ff @(posedge i_vga_clock or posedge i_reset) begin
    if (i_reset) begin
      r1_valid     <= 1'b0;
      r1_off       <= 1'b0;
      r1_x         <= '0;
      r1_y         <= '0;
      r1_col       <= '0;
      r1_row_bytes <= '0;
      r1_mario_x   <= '0;
      r1_mario_y   <= '0;
      r1_goomba_x  <= '0;
      r1_goomba_y  <= '0;
    end else begin
      r1_valid     <= i_pixel_valid;
      r1_off       <= w_off;
      r1_x         <= i_pixel_x;
      r1_y         <= i_pixel_y;
      r1_col       <= w_col;
      r1_row_bytes <= w_row_bytes;
      r1_mario_x   <= i_mario_x;
      r1_mario_y   <= i_mario_y;
      r1_goomba_x  <= i_goomba_x;
      r1_goomba_y  <= i_goomba_y;
    end
  end

  // Tile select within the captured row and sprite hit tests.
  always_comb begin
    w_code       = r1_row_bytes[4'd15 - r1_col];
    w_mario_hit  = f_hit(r1_x, r1_mario_x) && f_hit(r1_y, r1_mario_y);
    w_goomba_hit = f_hit(r1_x, r1_goomba_x) && f_hit(r1_y, r1_goomba_y);
  end

  // Stage 2: tile code and sprite-hit flags.
  always_ff @(posedge i_vga_clock or posedge i_reset) begin
    if (i_reset) begin
      r2_valid  <= 1'b0;
      r2_off    <= 1'b0;
      r2_mario  <= 1'b0;
      r2_goomba <= 1'b0;
      r2_code   <= '0;
    end else begin
      r2_valid  <= r1_valid;
      r2_off    <= r1_off;
      r2_mario  <= w_mario_hit;
      r2_goomba <= w_goomba_hit;
      r2_code   <= w_code;
    end
  end

  // Final colour: blanking and off-screen black, then Mario > Goomba > tile.
  always_comb begin
    w_color = RGB_BLACK;
    if (r2_valid && !r2_off) begin
      if (r2_mario)       w_color = RGB_MARIO;
      else if (r2_goomba) w_color = RGB_GOOMBA;
      else                w_color = f_palette(r2_code, w_hide);
    end
  end

  // Stage 3: registered colour output.
  always_ff @(posedge i_vga_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rgb       <= RGB_BLACK;
      o_rgb_valid <= 1'b0;
    end else begin
      o_rgb       <= w_color;
      o_rgb_valid <= r2_valid;
    end
  end

`ifdef TILE_RENDERER_BLINK_EN
  localparam int unsigned BLINK_FRAMES = 30;

  typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_state_t;

  blink_state_t r_state;
  blink_state_t w_state_next;
  logic [5:0]   r_frame_cnt;
  logic [5:0]   w_frame_cnt_next;

  // Blink state and frame counter registers.
  always_ff @(posedge i_vga_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= SHOW;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  // Count frames; toggle visibility every BLINK_FRAMES frame starts.
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    if (i_frame_start) begin
      if (r_frame_cnt == 6'(BLINK_FRAMES - 1)) begin
        w_frame_cnt_next = '0;
        w_state_next     = (r_state == SHOW) ? HIDE : SHOW;
      end else begin
        w_frame_cnt_next = r_frame_cnt + 6'd1;
      end
    end
  end

  assign w_hide = (r_state == HIDE);
`else
  logic w_frame_start_unused;

  assign w_frame_start_unused = i_frame_start;
  assign w_hide               = 1'b0;
`endif

endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: directed and randomized checks of tile_renderer against a
// behavioural colour model with a fixed three-cycle latency scoreboard.
module tb_tile_renderer;

  logic                   clk;
  logic                   rst;
  logic [11:0][16:0][7:0] bg;
  logic [9:0]             px;
  logic [9:0]             py;
  logic                   pv;
  logic                   fs;
  logic signed [31:0]     mx;
  logic signed [31:0]     my;
  logic signed [31:0]     gx;
  logic signed [31:0]     gy;
  logic [11:0]            rgb;
  logic                   rgb_valid;

  int tests;
  int fails;
  int fs_count;

  typedef struct {
    bit          v;
    bit          tkn;
    logic [11:0] rgb;
    string       tag;
  } exp_t;

  exp_t q[$];

  logic [11:0] pal [0:6] = '{12'h000, 12'h6AF, 12'hA52, 12'h840, 12'hFD0, 12'hFFF, 12'h000};

  tile_renderer dut (
    .i_vga_clock   (clk),
    .i_reset       (rst),
    .i_background  (bg),
    .i_pixel_x     (px),
    .i_pixel_y     (py),
    .i_pixel_valid (pv),
    .i_frame_start (fs),
    .i_mario_x     (mx),
    .i_mario_y     (my),
    .i_goomba_x    (gx),
    .i_goomba_y    (gy),
    .o_rgb         (rgb),
    .o_rgb_valid   (rgb_valid)
  );

  always #5 clk = ~clk;

  function automatic bit inside_sprite(int x, int y, int sx, int sy);
    return (longint'(x) >= longint'(sx)) && (longint'(x) < longint'(sx) + 42) &&
           (longint'(y) >= longint'(sy)) && (longint'(y) < longint'(sy) + 42);
  endfunction

  // Expected output for a pixel given the current map and sprite positions.
  function automatic exp_t model(bit v, int x, int y, string tag);
    exp_t e;
    int   code;
    e.v = v; e.tkn = 1'b0; e.rgb = 12'h000; e.tag = tag;
    if (!v) return e;
    if (x >= 640 || y >= 480) return e;
    if (inside_sprite(x, y, mx, my)) e.rgb = 12'hF00;
    else if (inside_sprite(x, y, gx, gy)) e.rgb = 12'h830;
    else begin
      code = int'(bg[11 - y / 40][16 - x / 40]);
      if (code == 4) e.tkn = 1'b1;
      else if (code <= 6) e.rgb = pal[code];
      else e.rgb = 12'hF0F;
    end
    return e;
  endfunction

  function automatic bit hide_now();
`ifdef TILE_RENDERER_BLINK_EN
    return ((fs_count / 30) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string tag, logic [12:0] got, logic [12:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got valid=%0b rgb=%03h, expected valid=%0b rgb=%03h",
             tag, got[12], got[11:0], exp[12], exp[11:0]);
    end
  endtask

  // One clock: drive a pixel, advance, check the entry that reaches the output.
  task automatic cycle(bit v, int x, int y, bit f, string tag);
    exp_t        e;
    bit          h;
    logic [11:0] er;
    pv = v; px = 10'(x); py = 10'(y); fs = f;
    q.push_back(model(v, x, y, tag));
    h = hide_now();
    if (f) fs_count++;
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 3) begin
      e  = q.pop_front();
      er = e.tkn ? (h ? 12'h6AF : 12'hFD0) : e.rgb;
      check(e.tag, {rgb_valid, rgb}, {e.v, er});
    end
  endtask

  task automatic do_reset();
    exp_t idle;
    pv = 1'b1; px = 10'd0; py = 10'd0; fs = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async", {rgb_valid, rgb}, 13'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_held", {rgb_valid, rgb}, 13'h0000);
    rst = 1'b0;
    pv  = 1'b0;
    fs_count = 0;
    q.delete();
    idle.v = 1'b0; idle.tkn = 1'b0; idle.rgb = 12'h000; idle.tag = "post_rst";
    q.push_back(idle);
    q.push_back(idle);
  endtask

  task automatic flush(int n);
    repeat (n) cycle(1'b0, 0, 0, 1'b0, "idle");
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; pv = 1'b0; fs = 1'b0; px = '0; py = '0;
    tests = 0; fails = 0; fs_count = 0;
    mx = 2000; my = 2000; gx = 2000; gy = 2000;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        bg[r][c] = 8'($urandom_range(0, 8));

    @(negedge clk);
    do_reset();

    // First pixel after reset: border tile at the top-left corner.
    bg[11][16] = 8'd0;
    cycle(1'b1, 0, 0, 1'b0, "first_bdr");
    flush(2);

    // Ground tile lookup.
    bg[9][15] = 8'd3;
    cycle(1'b1, 45, 85, 1'b0, "gnd_45_85");
    flush(2);

    // Continuous scan of one row.
    for (int x = 0; x < 640; x++) cycle(1'b1, x, 85, 1'b0, "row85");
    flush(2);

    // Overlapping sprites and their edges.
    mx = 100; my = 100; gx = 120; gy = 120;
    cycle(1'b1, 130, 130, 1'b0, "mario_over");
    cycle(1'b1, 161, 161, 1'b0, "goomba_edge");
    cycle(1'b1, 162, 162, 1'b0, "past_goomba");
    cycle(1'b1, 141, 100, 1'b0, "mario_right");
    cycle(1'b1, 142, 100, 1'b0, "mario_past");
    flush(2);

    // Off-screen and negative sprite clipping.
    cycle(1'b1, 700, 10, 1'b0, "offscreen_x");
    cycle(1'b1, 10, 490, 1'b0, "offscreen_y");
    mx = -20; my = 190;
    cycle(1'b1, 21, 200, 1'b0, "mario_neg_in");
    cycle(1'b1, 22, 200, 1'b0, "mario_neg_out");
    cycle(1'b1, 0, 189, 1'b0, "mario_neg_above");
    flush(2);

    // Map write between consecutive pixels.
    mx = 2000; gx = 2000;
    bg[9][15] = 8'd3;
    cycle(1'b1, 45, 85, 1'b0, "bg_change_old");
    bg[9][15] = 8'd1;
    cycle(1'b1, 45, 85, 1'b0, "bg_change_new");
    flush(2);

    // Randomized traffic, including map/sprite changes and frame starts.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        mx = int'($urandom_range(0, 760)) - 60;
        my = int'($urandom_range(0, 560)) - 60;
        gx = int'($urandom_range(0, 760)) - 60;
        gy = int'($urandom_range(0, 560)) - 60;
      end
      if ($urandom_range(0, 19) == 0)
        bg[$urandom_range(0, 11)][$urandom_range(0, 16)] = 8'($urandom_range(0, 8));
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
            $urandom_range(0, 39) == 0, "random");
    end
    flush(2);

    // Coin blink sequence and reset while hidden.
    do_reset();
    mx = 2000; my = 2000; gx = 2000; gy = 2000;
    bg[6][6] = 8'd4;
    repeat (29) cycle(1'b0, 0, 0, 1'b1, "fs_idle");
    cycle(1'b1, 400, 200, 1'b0, "coin_29");
    flush(2);
    cycle(1'b0, 0, 0, 1'b1, "fs_idle");
    cycle(1'b1, 400, 200, 1'b0, "coin_30");
    flush(2);
    repeat (30) cycle(1'b0, 0, 0, 1'b1, "fs_idle");
    cycle(1'b1, 400, 200, 1'b0, "coin_60");
    flush(2);
    repeat (30) cycle(1'b0, 0, 0, 1'b1, "fs_idle");
    cycle(1'b1, 400, 200, 1'b0, "coin_90");
    flush(2);
    do_reset();
    cycle(1'b1, 400, 200, 1'b0, "coin_after_rst");
    flush(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
# tile_renderer

Pixel-pipeline reader of the level tile map. Takes the VGA scan position, looks up the tile code in the 12×17 `background` array driven by the active level, overlays the Mario and Goomba sprites, and emits a 12-bit colour three cycles later. Sits between the level modules (writers of `background`, `mario_*`, `goomba_*`) and the VGA output stage. It also owns coin (TKN) blink animation timing.

## Interface
- BDR, 0, border tile code
- SKY, 1, sky tile code
- BLK, 2, brick tile code
- GND, 3, ground tile code
- TKN, 4, coin tile code
- CK1, 5, checker tile A code
- CK2, 6, checker tile B code
- CHARACTER_WIDTH, 42, sprite edge length in pixels
- SCREEN_WIDTH, 640, visible width
- SCREEN_HEIGHT, 480, visible height
- BLOCK_WIDTH, 40, tile edge length in pixels
- BLINK_FRAMES, 30, frames per coin blink half-period (1..63)

- vga_clock  in  1  pixel clock, sole clock
- reset  in  1  asynchronous, active-high
- background  in  byte [11:0][16:0]  tile map, [y][x]
- pixel_x  in  10  scan column
- pixel_y  in  10  scan row
- pixel_valid  in  1  scan position in active video
- frame_start  in  1  one-cycle pulse at start of each frame
- mario_x, mario_y  in  int  Mario top-left, screen pixels
- goomba_x, goomba_y  in  int  Goomba top-left, screen pixels
- rgb  out  12  colour {r[3:0],g[3:0],b[3:0]}
- rgb_valid  out  1  rgb corresponds to a valid input pixel

## Operation
- Tile address: col = pixel_x / BLOCK_WIDTH, row = pixel_y / BLOCK_WIDTH; code = background[11−row][16−col]. Screen top-left is background[11][16]; element x=0 is never displayed.
- Division by the constant BLOCK_WIDTH is a subtract/compare chain, not a generic divider.
- Off-screen: pixel_x ≥ SCREEN_WIDTH or pixel_y ≥ SCREEN_HEIGHT with pixel_valid=1 → rgb 0x000, rgb_valid=1.
- Sprite hit: x ∈ [sx, sx+CHARACTER_WIDTH) and y ∈ [sy, sy+CHARACTER_WIDTH), signed 32-bit compare. Negative sprite coordinates clip correctly.
- Priority: Mario 0xF00 > Goomba 0x830 > tile.
- Palette: BDR 0x000, SKY 0x6AF, BLK 0xA52, GND 0x840, TKN 0xFD0, CK1 0xFFF, CK2 0x000, any other code 0xF0F.
- Blink FSM has two states, SHOW and HIDE, plus a 6-bit frame counter.
  - Each frame_start increments the counter.
  - When the counter reaches BLINK_FRAMES−1, it clears and the state toggles.
  - In HIDE, TKN renders as SKY colour.
- pixel_valid=0 → rgb_valid=0, rgb=0x000.
- `background` and sprite inputs are sampled in stage 1. A mid-frame change affects only pixels entering after it.

## Timing
- Three-stage pipeline; pixel presented at cycle N appears on rgb/rgb_valid after edge N+3. Throughput 1 pixel/cycle, no stalls, no backpressure.
- Stage 1: register pixel, sprite coordinates, row/col, and off-screen flag.
- Stage 2: register tile code and sprite-hit flags.
- Stage 3: register colour.
- Blink state is sampled in stage 3. A frame_start coincident with a valid pixel updates the blink state on that same edge.
- Reset (any time, asynchronous):
  - all stage valids clear;
  - rgb=0x000, rgb_valid=0;
  - frame counter 0, state SHOW.
- After reset deasserts, the first valid output is 3 cycles after the first valid input.

## Configuration
- TILE_RENDERER_BLINK_EN defined: blink FSM and frame counter as above.
- Undefined: counter and FSM absent, frame_start ignored, TKN always 0xFD0.

## Test plan
- Reset held, then released; drive (0,0) valid with background[11][16]=BDR and sprites far away → rgb 0x000 at cycle +3, rgb_valid 1; rgb 0x000 / rgb_valid 0 during reset.
- Pixel (45,85) with background[9][15]=GND and sprites off-screen → rgb 0x840 exactly 3 cycles later. Back-to-back (0..639, row 85) produces a continuous stream.
- Mario (100,100) and Goomba (120,120) overlap; pixel (130,130) → 0xF00; pixel (161,161) → 0x830; pixel (162,162) → tile colour.
- Pixel (700,10) valid → 0x000 with rgb_valid 1. Mario_x=−20: pixel (21,y) inside its rows → 0xF00, pixel (22,y) → tile.
- BLINK_EN: background[6][6]=TKN at pixel (400,200). After 29 frame_starts → 0xFD0; after 30th → 0x6AF; after 60th → 0xFD0. Reset mid-HIDE → 0xFD0.
- Change background[9][15] from GND to SKY between two consecutive valid pixels (45,85) → outputs 0x840 then 0x6AF, in order, with no gap.
